conv3x3_ctrl: RTL and testbench
===============================

Name: conv3x3_ctrl

Overview:
Sequencer for the 3x3 convolution core over one IMG_W x IMG_H feature map.
- Loads the 9 weights and the bias through a serial config port.
- Accepts a raster-order pixel stream, tracks row and column, and generates the core's per-window valid strobe.
- Counts the core's output pixels, then signals frame completion.
- Sits between the stream source or line-buffer front end and the convolution core; the weight registers live here and stay resident across frames.

Parameters:
DATA_WIDTH, 8, width of pixels, weights, bias and cfg words
IMG_W, 8, frame width in pixels (>=3)
IMG_H, 8, frame height in pixels (>=3)
NUM_W, 10, config words per load: w00,w01,w02,w10,w11,w12,w20,w21,w22,bias

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  pulse: begin a frame (ignored unless IDLE)
reload  in  1  sampled with start: 1 = load weights first; 0 = reuse resident weights
cfg_valid  in  1  config word valid
cfg_data  in  DATA_WIDTH  config word, signed
cfg_ready  out  1  high only in LOAD_W
pix_valid  in  1  stream pixel valid
pix_ready  out  1  high only in RUN
core_valid_in  out  1  window-complete strobe to the core
win_row  out  clog2(IMG_H)  top-left row of the current window
win_col  out  clog2(IMG_W)  top-left column of the current window
weights  out  NUM_W*DATA_WIDTH  packed w00 at LSB, bias at MSB
core_valid_out  in  1  core output-pixel strobe
w_loaded  out  1  resident weights are valid
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at frame end
err  out  1  sticky: core_valid_out seen in IDLE/LOAD_W; cleared by reset only

Behaviour:
- Reset (async assert, synchronous-release handling by top level):
  - state=IDLE; all counters=0; weights=0.
  - w_loaded, cfg_ready, pix_ready, core_valid_in, done, err, busy all 0; win_row and win_col 0.
- FSM states: IDLE, LOAD_W, RUN, DRAIN, DONE.
- IDLE:
  - start=1 with (reload=1 or w_loaded=0): go to LOAD_W.
  - start=1 with reload=0 and w_loaded=1: go to RUN.
  - start in any other state is ignored.
- LOAD_W:
  - cfg_ready=1. Each cfg_valid&&cfg_ready writes slot wcnt; wcnt then increments.
  - When slot NUM_W-1 is accepted: w_loaded=1, wcnt=0, go to RUN in the next cycle.
  - w_loaded drops to 0 on entry to LOAD_W, so a partially loaded set is never flagged as valid.
- RUN:
  - pix_ready=1. Each pix_valid&&pix_ready advances (row,col) in raster order; col wraps at IMG_W-1 and row then increments.
  - For the accepted pixel at (r,c) with r>=2 and c>=2: one cycle later, core_valid_in=1 with win_row=r-2, win_col=c-2.
  - core_valid_in is otherwise 0. Its latency is exactly 1 cycle from acceptance; it is never stalled.
  - On acceptance of (IMG_H-1, IMG_W-1): go to DRAIN, and (row,col) returns to (0,0).
- Output counting (RUN and DRAIN):
  - out_cnt counts core_valid_out pulses; expected total is (IMG_W-2)*(IMG_H-2).
  - In DRAIN, pix_ready=0.
  - When out_cnt reaches the expected total (including a pulse arriving on the same cycle as DRAIN entry), go to DONE.
- DONE: done=1 for one cycle, out_cnt cleared, then IDLE.
- Bubbles: pix_valid gaps in RUN hold all counters and emit no core_valid_in.
- err: set by core_valid_out in IDLE or LOAD_W; such pulses are not counted.
- Reset mid-frame: immediate return to IDLE. Weights and w_loaded are cleared, so the next start must reload.
- Widths:
  - out_cnt is clog2((IMG_W-2)*(IMG_H-2)+1) bits.
  - All counters compare with equality only; no overflow is possible.

Decomposition:
- Shared package conv_pkg:
  - state encoding enum.
  - NUM_W.
  - Weight-slot index constants (W00..W22, BIAS).
  - clog2 function.
- One natural sub-module: conv_raster_cnt, the row/col counter with wrap, last-pixel and window-complete flags. The FSM, config load and output counter stay in the top.

Test Plan:
1. IMG_W=IMG_H=4. Reset, start with reload=1, send cfg 1..9 then bias 5.
   Required: weights packs 0x05090807060504030201, w_loaded=1, state=RUN.
2. Stream 16 pixels back-to-back.
   Required: exactly 4 core_valid_in pulses, win (row,col) = (0,0),(0,1),(1,0),(1,1), each 1 cycle after pixels 10,11,14,15 (0-based). Then return 4 core_valid_out pulses: done pulses once, busy falls.
3. Second start with reload=0.
   Required: RUN entered directly, cfg_ready stays 0, same weights are used.
4. Insert 2-cycle pix_valid gaps between every pixel.
   Required: identical win sequence, and no core_valid_in during the gaps.
5. Pulse core_valid_out while IDLE.
   Required: err=1 and stays 1. Then start: out_cnt is unaffected, and the frame still completes after exactly 4 outputs.
6. Assert rst_n low after 5 pixels of a frame.
   Required: outputs go to 0 asynchronously, w_loaded=0. A following start with reload=0 enters LOAD_W.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the 3x3 convolution sequencer.
//   state_t        FSM encoding
//   NUM_W          config words per weight load (9 taps + bias)
//   W00..W22,BIAS  slot index of each config word in the packed weight bus
//   clog2          width helper, never returns less than 1
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int NUM_W = 10;

  localparam int W00  = 0;
  localparam int W01  = 1;
  localparam int W02  = 2;
  localparam int W10  = 3;
  localparam int W11  = 4;
  localparam int W12  = 5;
  localparam int W20  = 6;
  localparam int W21  = 7;
  localparam int W22  = 8;
  localparam int BIAS = 9;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/conv_raster_cnt.sv
// conv_raster_cnt: raster-order row/column tracker for the pixel stream.
//   clk, rst_n  clock / async active-low reset
//   i_adv       advance one pixel (accepted pixel this cycle)
//   o_row/o_col position of the pixel currently offered
//   o_last      current position is the final pixel of the frame
//   o_win       current position completes a 3x3 window (row>=2, col>=2)
module conv_raster_cnt #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int RW    = 3,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_adv,
  output logic [RW-1:0] o_row,
  output logic [CW-1:0] o_col,
  output logic          o_last,
  output logic          o_win
);

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          w_col_end;
  logic          w_row_end;

  assign w_col_end = (r_col == CW'(IMG_W - 1));
  assign w_row_end = (r_row == RW'(IMG_H - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_adv) begin
      if (w_col_end) begin
        r_col <= '0;
        // last pixel wraps the whole frame back to (0,0)
        r_row <= w_row_end ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  assign o_row  = r_row;
  assign o_col  = r_col;
  assign o_last = w_row_end && w_col_end;
  assign o_win  = (r_row >= RW'(2)) && (r_col >= CW'(2));

endmodule

// File: rtl/conv3x3_ctrl.sv
// conv3x3_ctrl: sequencer for a 3x3 convolution core over one IMG_W x IMG_H map.
//   start/reload            begin a frame, optionally reloading weights first
//   cfg_valid/cfg_data/
//   cfg_ready               serial weight+bias load (w00..w22, bias)
//   pix_valid/pix_ready     raster pixel stream handshake
//   core_valid_in,
//   win_row/win_col         window-complete strobe + window top-left to core
//   weights                 resident weights, w00 at LSB, bias at MSB
//   core_valid_out          core result strobe, counted to detect frame end
//   w_loaded/busy/done/err  status
module conv3x3_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int NUM_W      = conv_pkg::NUM_W
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             reload,
  input  logic                             cfg_valid,
  input  logic [DATA_WIDTH-1:0]            cfg_data,
  output logic                             cfg_ready,
  input  logic                             pix_valid,
  output logic                             pix_ready,
  output logic                             core_valid_in,
  output logic [conv_pkg::clog2(IMG_H)-1:0] win_row,
  output logic [conv_pkg::clog2(IMG_W)-1:0] win_col,
  output logic [NUM_W*DATA_WIDTH-1:0]      weights,
  input  logic                             core_valid_out,
  output logic                             w_loaded,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);
  import conv_pkg::*;

  localparam int RW    = clog2(IMG_H);
  localparam int CW    = clog2(IMG_W);
  localparam int TOTAL = (IMG_W - 2) * (IMG_H - 2);
  localparam int OW    = clog2(TOTAL + 1);
  localparam int WCW   = clog2(NUM_W);

  state_t r_state, w_nxt;

  logic [NUM_W-1:0][DATA_WIDTH-1:0] r_weights;
  logic [WCW-1:0]                   r_wcnt;
  logic                             r_w_loaded;
  logic                             r_cvi;
  logic [RW-1:0]                    r_win_row;
  logic [CW-1:0]                    r_win_col;
  logic [OW-1:0]                    r_out_cnt;
  logic                             r_err;

  logic          w_cfg_acc, w_cfg_last, w_pix_acc;
  logic          w_last_pix, w_win;
  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col;
  logic          w_counting, w_cnt_hit, w_load_entry;

  assign w_cfg_acc    = cfg_valid && (r_state == ST_LOAD_W);
  assign w_cfg_last   = (r_wcnt == WCW'(NUM_W - 1));
  assign w_pix_acc    = pix_valid && (r_state == ST_RUN);
  assign w_counting   = core_valid_out && ((r_state == ST_RUN) || (r_state == ST_DRAIN));
  // the final result may arrive in the same cycle the check is made
  assign w_cnt_hit    = (r_out_cnt == OW'(TOTAL)) ||
                        (core_valid_out && (r_out_cnt == OW'(TOTAL - 1)));
  assign w_load_entry = (r_state == ST_IDLE) && (w_nxt == ST_LOAD_W);

  conv_raster_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .RW    (RW),
    .CW    (CW)
  ) u_raster (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_adv  (w_pix_acc),
    .o_row  (w_row),
    .o_col  (w_col),
    .o_last (w_last_pix),
    .o_win  (w_win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_nxt = (reload || !r_w_loaded) ? ST_LOAD_W : ST_RUN;
      ST_LOAD_W: if (w_cfg_acc && w_cfg_last) w_nxt = ST_RUN;
      ST_RUN:    if (w_pix_acc && w_last_pix) w_nxt = ST_DRAIN;
      ST_DRAIN:  if (w_cnt_hit) w_nxt = ST_DONE;
      ST_DONE:   w_nxt = ST_IDLE;
      default:   w_nxt = ST_IDLE;
    endcase
  end

  // weight load; the valid flag drops as soon as a reload begins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_weights  <= '0;
      r_wcnt     <= '0;
      r_w_loaded <= 1'b0;
    end else if (w_load_entry) begin
      r_wcnt     <= '0;
      r_w_loaded <= 1'b0;
    end else if (w_cfg_acc) begin
      r_weights[r_wcnt] <= cfg_data;
      if (w_cfg_last) begin
        r_wcnt     <= '0;
        r_w_loaded <= 1'b1;
      end else begin
        r_wcnt <= r_wcnt + WCW'(1);
      end
    end
  end

  // window strobe: fixed one-cycle latency from pixel acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cvi     <= 1'b0;
      r_win_row <= '0;
      r_win_col <= '0;
    end else begin
      r_cvi <= w_pix_acc && w_win;
      if (w_pix_acc && w_win) begin
        r_win_row <= w_row - RW'(2);
        r_win_col <= w_col - CW'(2);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      if (r_state == ST_DONE)
        r_out_cnt <= '0;
      else if (w_counting && (r_out_cnt != OW'(TOTAL)))
        r_out_cnt <= r_out_cnt + OW'(1);
      if (core_valid_out && ((r_state == ST_IDLE) || (r_state == ST_LOAD_W)))
        r_err <= 1'b1;
    end
  end

  assign cfg_ready     = (r_state == ST_LOAD_W);
  assign pix_ready     = (r_state == ST_RUN);
  assign core_valid_in = r_cvi;
  assign win_row       = r_win_row;
  assign win_col       = r_win_col;
  assign weights       = r_weights;
  assign w_loaded      = r_w_loaded;
  assign busy          = (r_state != ST_IDLE);
  assign done          = (r_state == ST_DONE);
  assign err           = r_err;

endmodule

// File: tb/tb_conv3x3_ctrl.sv
module tb_conv3x3_ctrl;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int NW = 10;
  localparam int RW = conv_pkg::clog2(H);
  localparam int CW = conv_pkg::clog2(W);

  logic                clk, rst_n, start, reload, cfg_valid, cfg_ready;
  logic [DW-1:0]       cfg_data;
  logic                pix_valid, pix_ready, core_valid_in, core_valid_out;
  logic [RW-1:0]       win_row;
  logic [CW-1:0]       win_col;
  logic [NW*DW-1:0]    weights;
  logic                w_loaded, busy, done, err;

  conv3x3_ctrl #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .NUM_W(NW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .reload(reload),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .core_valid_in(core_valid_in), .win_row(win_row), .win_col(win_col),
    .weights(weights), .core_valid_out(core_valid_out),
    .w_loaded(w_loaded), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int r; int c; int t; } win_t;
  win_t q[$];

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;

  // hand-computed for a 4x4 frame: pixels 10,11,14,15 close windows
  int trig[4] = '{10, 11, 14, 15};
  int er[4]   = '{0, 0, 1, 1};
  int ec[4]   = '{0, 1, 0, 1};
  logic [NW*DW-1:0] exp_w = 80'h05090807060504030201;
  logic [DW-1:0]    cfg_vals[NW] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd5};

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    win_t e;
    if (rst_n && core_valid_in) begin
      if (q.size() == 0) begin
        chk("spurious core_valid_in", {127'd0, core_valid_in}, 128'd0);
      end else begin
        e = q.pop_front();
        chk("win_row", win_row, e.r);
        chk("win_col", win_col, e.c);
        chk("core_valid_in cycle", cyc, e.t);
      end
    end
    if (rst_n && done) done_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic rl);
    start = 1'b1; reload = rl;
    tick;
    start = 1'b0; reload = 1'b0;
  endtask

  task automatic load_w;
    for (int i = 0; i < NW; i++) begin
      cfg_valid = 1'b1; cfg_data = cfg_vals[i];
      tick;
    end
    cfg_valid = 1'b0; cfg_data = '0;
  endtask

  task automatic send_frame(input int gap, input logic cvo_on_last);
    for (int i = 0; i < W*H; i++) begin
      pix_valid = 1'b1;
      for (int k = 0; k < 4; k++)
        if (i == trig[k]) q.push_back('{er[k], ec[k], cyc + 1});
      if (i == W*H-1) core_valid_out = cvo_on_last;
      tick;
      pix_valid = 1'b0; core_valid_out = 1'b0;
      if (i != W*H-1) repeat (gap) tick;
    end
  endtask

  task automatic pulse_cvo(input int n);
    repeat (n) begin
      core_valid_out = 1'b1; tick;
      core_valid_out = 1'b0; tick;
    end
  endtask

  task automatic wait_done(input string nm, input int base);
    for (int k = 0; k < 20; k++) begin
      if (done_cnt != base) break;
      tick;
    end
    repeat (3) tick;
    chk({nm, " done pulses"}, done_cnt - base, 1);
    chk({nm, " busy after done"}, busy, 0);
  endtask

  initial begin
    int base;
    rst_n = 1'b0; start = 1'b0; reload = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    pix_valid = 1'b0; core_valid_out = 1'b0;
    #2;
    chk("rst busy", busy, 0);
    chk("rst cfg_ready", cfg_ready, 0);
    chk("rst pix_ready", pix_ready, 0);
    chk("rst core_valid_in", core_valid_in, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst w_loaded", w_loaded, 0);
    chk("rst weights", weights, 0);
    chk("rst win_row", win_row, 0);
    chk("rst win_col", win_col, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick;

    // 1: load weights
    start_frame(1'b1);
    chk("t1 cfg_ready in load", cfg_ready, 1);
    chk("t1 w_loaded during load", w_loaded, 0);
    load_w;
    chk("t1 weights", weights, exp_w);
    chk("t1 w_loaded", w_loaded, 1);
    chk("t1 pix_ready (RUN)", pix_ready, 1);
    chk("t1 cfg_ready after load", cfg_ready, 0);

    // 2: back-to-back frame, then 4 results
    base = done_cnt;
    send_frame(0, 1'b0);
    chk("t2 pix_ready in drain", pix_ready, 0);
    chk("t2 busy in drain", busy, 1);
    pulse_cvo(3);
    chk("t2 no early done", done_cnt - base, 0);
    pulse_cvo(1);
    wait_done("t2", base);
    chk("t2 pending windows", q.size(), 0);

    // 3+4: reuse weights, gapped stream, first result on drain entry
    start_frame(1'b0);
    chk("t3 pix_ready direct", pix_ready, 1);
    chk("t3 cfg_ready", cfg_ready, 0);
    chk("t3 weights kept", weights, exp_w);
    base = done_cnt;
    send_frame(2, 1'b1);
    pulse_cvo(2);
    chk("t4 no early done", done_cnt - base, 0);
    pulse_cvo(1);
    wait_done("t4", base);
    chk("t4 pending windows", q.size(), 0);

    // 5: stray result while idle
    pulse_cvo(1);
    chk("t5 err set", err, 1);
    start_frame(1'b0);
    chk("t5 pix_ready", pix_ready, 1);
    base = done_cnt;
    send_frame(0, 1'b0);
    pulse_cvo(3);
    chk("t5 no early done", done_cnt - base, 0);
    pulse_cvo(1);
    wait_done("t5", base);
    chk("t5 err sticky", err, 1);

    // 6: reset mid-frame
    start_frame(1'b0);
    for (int i = 0; i < 5; i++) begin
      pix_valid = 1'b1; tick;
    end
    pix_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6 busy async", busy, 0);
    chk("t6 pix_ready async", pix_ready, 0);
    chk("t6 w_loaded async", w_loaded, 0);
    chk("t6 weights async", weights, 0);
    chk("t6 err cleared", err, 0);
    chk("t6 core_valid_in", core_valid_in, 0);
    tick;
    rst_n = 1'b1;
    tick;
    start_frame(1'b0);
    chk("t6 reload forced cfg_ready", cfg_ready, 1);
    chk("t6 pix_ready", pix_ready, 0);
    chk("t6 busy", busy, 1);
    chk("t6 pending windows", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
